// File: rtl/linear_cordic_div_prenorm.sv
// Operand pre-normaliser for the linear CORDIC divide pipeline: folds the sign of X into Y,
// scales X'/Y' into the convergence range one shift per cycle and tracks the post-scale exponent.
module linear_cordic_div_prenorm #(
    parameter int WIDTH   = 16,
    parameter int FRAC    = 14,
    parameter int SHIFT_W = 5
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_x,
    input  logic [WIDTH-1:0]   in_y,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_x,
    output logic [WIDTH-1:0]   out_y,
    output logic [WIDTH-1:0]   out_z,
    output logic [SHIFT_W-1:0] out_shift,
    output logic               out_div0
);

    localparam logic signed [WIDTH-1:0] S_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] S_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] ONE    = WIDTH'(1 << FRAC);
    localparam logic signed [WIDTH-1:0] X_LOW  = WIDTH'(1 << (FRAC - 1));

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_NORM  = 2'd1,
        S_ISSUE = 2'd2
    } state_t;

    state_t                    state_q;
    logic signed [WIDTH-1:0]   x_q;
    logic signed [WIDTH-1:0]   y_q;
    logic [SHIFT_W-1:0]        k_q;
    logic                      div0_q;
    logic                      out_valid_q;
    logic                      in_ready_q;

    // Negation that maps the one unrepresentable case onto the largest positive value.
    function automatic logic signed [WIDTH-1:0] sat_neg(input logic signed [WIDTH-1:0] v);
        if (v == S_MIN) begin
            return S_MAX;
        end
        return -v;
    endfunction

    // Magnitude widened by one bit so that |S_MIN| is representable.
    function automatic logic signed [WIDTH:0] abs_ext(input logic signed [WIDTH-1:0] v);
        logic signed [WIDTH:0] e;
        e = {v[WIDTH-1], v};
        return (e < 0) ? -e : e;
    endfunction

    logic signed [WIDTH-1:0] in_x_s;
    logic signed [WIDTH-1:0] in_y_s;
    logic signed [WIDTH-1:0] x_d;
    logic signed [WIDTH-1:0] y_d;
    logic signed [WIDTH:0]   y_mag;
    logic signed [WIDTH:0]   x_ext;
    logic                    need_x_shift;
    logic                    need_y_shift;

    assign in_x_s = in_x;
    assign in_y_s = in_y;

    always_comb begin
        x_d = in_x_s;
        y_d = in_y_s;
        if (in_x_s < 0) begin
            x_d = sat_neg(in_x_s);
            y_d = sat_neg(in_y_s);
        end
    end

    assign y_mag        = abs_ext(y_q);
    assign x_ext        = {x_q[WIDTH-1], x_q};
    assign need_x_shift = (x_q < X_LOW);
    assign need_y_shift = (y_mag >= x_ext);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            k_q         <= '0;
            div0_q      <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        x_q        <= x_d;
                        y_q        <= y_d;
                        k_q        <= '0;
                        div0_q     <= (in_x_s == '0);
                        in_ready_q <= 1'b0;
                        state_q    <= S_NORM;
                    end
                end
                S_NORM: begin
                    // One shift per cycle; X is brought up first, then Y is brought below X.
                    if (div0_q) begin
                        x_q     <= ONE;
                        y_q     <= '0;
                        k_q     <= '0;
                        state_q <= S_ISSUE;
                    end else if (need_x_shift) begin
                        x_q <= x_q <<< 1;
                        k_q <= k_q + 1'b1;
                    end else if (need_y_shift) begin
                        y_q <= y_q >>> 1;
                        k_q <= k_q + 1'b1;
                    end else begin
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_x     = x_q;
    assign out_y     = y_q;
    assign out_z     = '0;
    assign out_shift = k_q;
    assign out_div0  = div0_q;

endmodule

// File: tb/tb_linear_cordic_div_prenorm.sv
// Bench for the CORDIC divide pre-normaliser: directed vector table, backpressure and
// reset corner sequences, and random requests checked against an arithmetic reference.
module tb_linear_cordic_div_prenorm;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_x;
    logic [15:0] in_y;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_x;
    logic [15:0] out_y;
    logic [15:0] out_z;
    logic [4:0]  out_shift;
    logic        out_div0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    linear_cordic_div_prenorm #(.WIDTH(16), .FRAC(14), .SHIFT_W(5)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_z     (out_z),
        .out_shift (out_shift),
        .out_div0  (out_div0)
    );

    typedef struct {
        logic signed [15:0] x;
        logic signed [15:0] y;
        int ex;
        int ey;
        int ek;
        int ed;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: Y/X rewritten as (Y'/X') * 2^k with X' in [8192, 32767] and |Y'| < X'.
    function automatic void model(input logic signed [15:0] x, input logic signed [15:0] y,
                                  output int ex, output int ey, output int ek, output int ed);
        int xi;
        int yi;
        ek = 0;
        if (x == 0) begin
            ex = 16384; ey = 0; ed = 1;
            return;
        end
        ed = 0;
        xi = x;
        yi = y;
        if (xi < 0) begin
            xi = -xi;
            yi = -yi;
        end
        if (xi > 32767) xi = 32767;
        if (yi > 32767) yi = 32767;
        while (xi < 8192) begin
            xi = xi * 2;
            ek++;
        end
        while (((yi < 0) ? -yi : yi) >= xi) begin
            yi = (yi < 0) ? -((-yi + 1) / 2) : yi / 2;
            ek++;
        end
        ex = xi;
        ey = yi;
    endfunction

    // Issue one request, measure latency, hold out_ready low for 'hold' cycles, then drain.
    task automatic do_req(input string tag, input logic signed [15:0] x, input logic signed [15:0] y,
                          input int ex, input int ey, input int ek, input int ed, input int hold);
        int lat;
        int guard;
        @(negedge clk);
        in_valid = 1'b1;
        in_x     = x;
        in_y     = y;
        guard    = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check({tag, " in_ready before accept"}, int'(in_ready), 1);
        @(posedge clk);
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) break;
            @(posedge clk);
            lat++;
        end
        check({tag, " out_valid"}, int'(out_valid), 1);
        check({tag, " latency"}, lat, 2 + ek);
        check({tag, " out_x"}, int'($signed(out_x)), ex);
        check({tag, " out_y"}, int'($signed(out_y)), ey);
        check({tag, " out_shift"}, int'(out_shift), ek);
        check({tag, " out_div0"}, int'(out_div0), ed);
        check({tag, " out_z"}, int'(out_z), 0);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_x     = 16'h1234;
            in_y     = 16'h0042;
            @(negedge clk);
            check({tag, " held out_valid"}, int'(out_valid), 1);
            check({tag, " held out_x"}, int'($signed(out_x)), ex);
            check({tag, " held out_y"}, int'($signed(out_y)), ey);
            check({tag, " held out_shift"}, int'(out_shift), ek);
            check({tag, " held in_ready"}, int'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " out_valid after handshake"}, int'(out_valid), 0);
        check({tag, " in_ready after handshake"}, int'(in_ready), 1);
    endtask

    initial begin
        int ex, ey, ek, ed, seen;
        logic signed [15:0] rx, ry;

        tbl[0] = '{x:16'sd16384,  y:16'sd8192,   ex:16384, ey:8192,  ek:0,  ed:0};
        tbl[1] = '{x:16'sd8192,   y:16'sd16384,  ex:8192,  ey:4096,  ek:2,  ed:0};
        tbl[2] = '{x:-16'sd8192,  y:16'sd4096,   ex:8192,  ey:-4096, ek:0,  ed:0};
        tbl[3] = '{x:-16'sd32768, y:-16'sd32768, ex:32767, ey:16383, ek:1,  ed:0};
        tbl[4] = '{x:16'sd1024,   y:16'sd512,    ex:8192,  ey:512,   ek:3,  ed:0};
        tbl[5] = '{x:16'sd0,      y:16'sd1234,   ex:16384, ey:0,     ek:0,  ed:1};
        tbl[6] = '{x:16'sd1,      y:16'sd1,      ex:8192,  ey:1,     ek:13, ed:0};
        tbl[7] = '{x:16'sd8192,   y:-16'sd8192,  ex:8192,  ey:-4096, ek:1,  ed:0};

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_x      = '0;
        in_y      = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", int'(out_valid), 0);
        check("reset in_ready", int'(in_ready), 1);
        check("reset out_x", int'(out_x), 0);
        check("reset out_y", int'(out_y), 0);
        check("reset out_shift", int'(out_shift), 0);
        check("reset out_div0", int'(out_div0), 0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            do_req($sformatf("vec%0d", i), tbl[i].x, tbl[i].y,
                   tbl[i].ex, tbl[i].ey, tbl[i].ek, tbl[i].ed, 0);
        end

        // Backpressure: five cycles of out_ready low with a competing in_valid present.
        do_req("backpressure", 16'sd16384, 16'sd8192, 16384, 8192, 0, 0, 5);
        @(negedge clk);
        check("no stray accept in_ready", int'(in_ready), 1);
        check("no stray accept out_valid", int'(out_valid), 0);

        // Reset pulse while the X=1 request is still shifting.
        @(negedge clk);
        in_valid = 1'b1;
        in_x     = 16'sd1;
        in_y     = 16'sd1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid-norm in_ready low", int'(in_ready), 0);
        reset_n = 1'b0;
        #1;
        check("reset pulse out_valid", int'(out_valid), 0);
        check("reset pulse out_shift", int'(out_shift), 0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("after reset in_ready", int'(in_ready), 1);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("no stale output", seen, 0);
        do_req("post-reset", 16'sd16384, 16'sd8192, 16384, 8192, 0, 0, 0);

        for (int i = 0; i < 200; i++) begin
            rx = 16'($urandom);
            ry = 16'($urandom);
            if (i % 4 == 0) rx = 16'($urandom_range(0, 300)) - 16'sd150;
            model(rx, ry, ex, ey, ek, ed);
            do_req($sformatf("rand%0d", i), rx, ry, ex, ey, ek, ed, int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
